// File: rtl/ast_mux.sv
// ast_mux: packet-aware N:1 Avalon-ST multiplexer, round-robin arbitration on packet boundaries.
// Optional: define AST_MUX_CHANNEL_FROM_DIR_EN to drive ast_channel_o from the grant index.
module ast_mux #(
  parameter int DATA_WIDTH    = 64,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int CHANNEL_WIDTH = 10,
  parameter int RX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = $clog2(RX_DIR)
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic [RX_DIR*DATA_WIDTH-1:0]      ast_data_i,
  input  logic [RX_DIR-1:0]                 ast_startofpacket_i,
  input  logic [RX_DIR-1:0]                 ast_endofpacket_i,
  input  logic [RX_DIR-1:0]                 ast_valid_i,
  input  logic [RX_DIR*EMPTY_WIDTH-1:0]     ast_empty_i,
  input  logic [RX_DIR*CHANNEL_WIDTH-1:0]   ast_channel_i,
  output logic [RX_DIR-1:0]                 ast_ready_o,
  output logic [DATA_WIDTH-1:0]             ast_data_o,
  output logic                              ast_startofpacket_o,
  output logic                              ast_endofpacket_o,
  output logic                              ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]            ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0]          ast_channel_o,
  output logic [DIR_SEL_WIDTH-1:0]          dir_o,
  input  logic                              ast_ready_i
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                     state_q;
  logic [DIR_SEL_WIDTH-1:0]   gnt_q;
  logic [DIR_SEL_WIDTH-1:0]   rr_ptr_q;

  logic [DATA_WIDTH-1:0]      data_q;
  logic                       sop_q;
  logic                       eop_q;
  logic                       valid_q;
  logic [EMPTY_WIDTH-1:0]     empty_q;
  logic [CHANNEL_WIDTH-1:0]   chan_q;
  logic [DIR_SEL_WIDTH-1:0]   dir_q;

  logic [RX_DIR-1:0][DATA_WIDTH-1:0]  data_a;
  logic [RX_DIR-1:0][EMPTY_WIDTH-1:0] empty_a;

  assign data_a  = ast_data_i;
  assign empty_a = ast_empty_i;

  // Round-robin search starting just after the last packet's source.
  logic                     gnt_vld_d;
  logic [DIR_SEL_WIDTH-1:0] gnt_d;

  always_comb begin
    int k;
    k         = 0;
    gnt_vld_d = 1'b0;
    gnt_d     = '0;
    for (int i = 1; i <= RX_DIR; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= RX_DIR) k = k - RX_DIR;
      if (!gnt_vld_d && ast_valid_i[DIR_SEL_WIDTH'(k)]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = DIR_SEL_WIDTH'(k);
      end
    end
  end

  // Ready is gated by srst so no input sees a transfer while the block is being reset.
  logic busy_ok;
  logic fwd_rdy;
  logic in_xfer;
  logic out_xfer;

  assign busy_ok  = (state_q == BUSY) && !srst;
  assign fwd_rdy  = ast_ready_i | ~valid_q;
  assign in_xfer  = busy_ok && ast_valid_i[gnt_q] && fwd_rdy;
  assign out_xfer = valid_q && ast_ready_i;

  for (genvar k = 0; k < RX_DIR; k++) begin : g_rdy
    assign ast_ready_o[k] = busy_ok && (gnt_q == DIR_SEL_WIDTH'(k)) && fwd_rdy;
  end

  logic [CHANNEL_WIDTH-1:0] chan_sel;

`ifdef AST_MUX_CHANNEL_FROM_DIR_EN
  if (CHANNEL_WIDTH < DIR_SEL_WIDTH) begin : g_chan_chk
    $error("ast_mux: CHANNEL_WIDTH must be >= DIR_SEL_WIDTH when channel comes from grant");
  end
  logic unused_chan_in;
  assign unused_chan_in = ^ast_channel_i;
  assign chan_sel       = CHANNEL_WIDTH'(gnt_q);
`else
  logic [RX_DIR-1:0][CHANNEL_WIDTH-1:0] chan_a;
  assign chan_a   = ast_channel_i;
  assign chan_sel = chan_a[gnt_q];
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= DIR_SEL_WIDTH'(RX_DIR - 1);
      data_q   <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      valid_q  <= 1'b0;
      empty_q  <= '0;
      chan_q   <= '0;
      dir_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            gnt_q   <= gnt_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && ast_endofpacket_i[gnt_q]) begin
            state_q  <= IDLE;
            rr_ptr_q <= gnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Loading takes priority over draining so back-to-back words keep full throughput.
      if (in_xfer) begin
        data_q  <= data_a[gnt_q];
        sop_q   <= ast_startofpacket_i[gnt_q];
        eop_q   <= ast_endofpacket_i[gnt_q];
        empty_q <= empty_a[gnt_q];
        chan_q  <= chan_sel;
        dir_q   <= gnt_q;
        valid_q <= 1'b1;
      end else if (out_xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign ast_data_o          = data_q;
  assign ast_startofpacket_o = sop_q;
  assign ast_endofpacket_o   = eop_q;
  assign ast_valid_o         = valid_q;
  assign ast_empty_o         = empty_q;
  assign ast_channel_o       = chan_q;
  assign dir_o               = dir_q;

endmodule

// File: tb/tb_ast_mux.sv
// tb_ast_mux: directed checks of arbitration order, throughput, backpressure and reset for ast_mux.
module tb_ast_mux;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CW = 10;
  localparam int N  = 4;
  localparam int SW = 2;

  logic               clk = 1'b0;
  logic               srst;
  logic [N-1:0][DW-1:0] in_data;
  logic [N-1:0]       in_sop, in_eop, in_vld;
  logic [N-1:0][EW-1:0] in_emp;
  logic [N-1:0][CW-1:0] in_ch;
  logic [N-1:0]       rdy_o;
  logic [DW-1:0]      d_o;
  logic               sop_o, eop_o, vld_o;
  logic [EW-1:0]      emp_o;
  logic [CW-1:0]      ch_o;
  logic [SW-1:0]      dir_o;
  logic               rdy_i;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ast_mux #(
    .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW), .RX_DIR(N), .DIR_SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .srst(srst),
    .ast_data_i(in_data), .ast_startofpacket_i(in_sop), .ast_endofpacket_i(in_eop),
    .ast_valid_i(in_vld), .ast_empty_i(in_emp), .ast_channel_i(in_ch),
    .ast_ready_o(rdy_o),
    .ast_data_o(d_o), .ast_startofpacket_o(sop_o), .ast_endofpacket_o(eop_o),
    .ast_valid_o(vld_o), .ast_empty_o(emp_o), .ast_channel_o(ch_o),
    .dir_o(dir_o), .ast_ready_i(rdy_i)
  );

  function automatic logic [DW-1:0] dw(int k, int w);
    return 64'hA5A5_0000_0000_0000 | (64'(k) << 16) | 64'(w);
  endfunction

  function automatic logic [CW-1:0] ech(int k);
`ifdef AST_MUX_CHANNEL_FROM_DIR_EN
    return CW'(k);
`else
    return CW'(64 + k);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int k, input int w, input logic sop, input logic eop, input int emp);
    in_vld[k]  = 1'b1;
    in_data[k] = dw(k, w);
    in_sop[k]  = sop;
    in_eop[k]  = eop;
    in_emp[k]  = EW'(emp);
    in_ch[k]   = CW'(64 + k);
  endtask

  task automatic drop(input int k);
    in_vld[k] = 1'b0;
  endtask

  // Control fields packed as {valid, sop, eop, empty, dir, channel}.
  task automatic chk_word(input string tag, input int k, input int w,
                          input logic sop, input logic eop, input int emp);
    chk({tag, "_data"}, 64'(d_o), 64'(dw(k, w)));
    chk({tag, "_ctrl"}, 64'({vld_o, sop_o, eop_o, emp_o, dir_o, ch_o}),
        64'({1'b1, sop, eop, EW'(emp), SW'(k), ech(k)}));
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 64'(vld_o), 64'h0);
  endtask

  initial begin
    srst = 1'b1; rdy_i = 1'b1;
    in_vld = '0; in_sop = '0; in_eop = '0; in_data = '0; in_emp = '0; in_ch = '0;

    // Reset with every input requesting
    for (int k = 0; k < N; k++) put(k, 0, 1'b1, 1'b1, 0);
    tick();
    chk("rst0_vld", 64'(vld_o), 64'h0);
    chk("rst0_rdy", 64'(rdy_o), 64'h0);
    chk("rst0_data", 64'(d_o), 64'h0);
    tick();
    chk("rst1_ctrl", 64'({vld_o, sop_o, eop_o, emp_o, dir_o, ch_o}), 64'h0);
    chk("rst1_rdy", 64'(rdy_o), 64'h0);
    srst = 1'b0;
    #1 chk("rst_post_rdy", 64'(rdy_o), 64'h0);
    tick();
    chk("rst_gnt0", 64'(rdy_o), 64'h1);
    chk_idle("rst_bubble");
    tick();
    chk_word("rst_w", 0, 0, 1'b1, 1'b1, 0);
    for (int k = 0; k < N; k++) drop(k);
    tick();
    chk_idle("rst_drain");

    // Single 3-word packet on input 2
    put(2, 0, 1'b1, 1'b0, 0);
    #1 chk("sp_rdy_idle", 64'(rdy_o), 64'h0);
    tick();
    chk("sp_gnt", 64'(rdy_o), 64'h4);
    chk_idle("sp_bubble");
    tick();
    chk_word("sp_w0", 2, 0, 1'b1, 1'b0, 0);
    put(2, 1, 1'b0, 1'b0, 0);
    #1 chk("sp_rdy_w1", 64'(rdy_o), 64'h4);
    tick();
    chk_word("sp_w1", 2, 1, 1'b0, 1'b0, 0);
    put(2, 2, 1'b0, 1'b1, 3);
    tick();
    chk_word("sp_w2", 2, 2, 1'b0, 1'b1, 3);
    drop(2);
    tick();
    chk_idle("sp_done");

    // Contention between inputs 0, 1 and 3 from a fresh pointer
    srst = 1'b1; tick(); srst = 1'b0; tick();
    put(0, 0, 1'b1, 1'b0, 0); put(1, 0, 1'b1, 1'b0, 0); put(3, 0, 1'b1, 1'b0, 0);
    tick();
    chk("ct_gnt0", 64'(rdy_o), 64'h1);
    tick();
    chk_word("ct_0a", 0, 0, 1'b1, 1'b0, 0);
    put(0, 1, 1'b0, 1'b1, 0);
    tick();
    chk_word("ct_0b", 0, 1, 1'b0, 1'b1, 0);
    drop(0);
    tick();
    chk_idle("ct_gap01");
    chk("ct_gnt1", 64'(rdy_o), 64'h2);
    tick();
    chk_word("ct_1a", 1, 0, 1'b1, 1'b0, 0);
    put(1, 1, 1'b0, 1'b1, 0);
    tick();
    chk_word("ct_1b", 1, 1, 1'b0, 1'b1, 0);
    drop(1);
    tick();
    chk_idle("ct_gap13");
    chk("ct_gnt3", 64'(rdy_o), 64'h8);
    tick();
    chk_word("ct_3a", 3, 0, 1'b1, 1'b0, 0);
    put(3, 1, 1'b0, 1'b1, 0);
    tick();
    chk_word("ct_3b", 3, 1, 1'b0, 1'b1, 0);
    drop(3);
    put(0, 2, 1'b1, 1'b1, 0); put(1, 2, 1'b1, 1'b1, 0);
    tick();
    chk_idle("ct_gap30");
    chk("ct_wrap_gnt0", 64'(rdy_o), 64'h1);
    tick();
    chk_word("ct_wrap_w0", 0, 2, 1'b1, 1'b1, 0);
    drop(0);
    tick();
    chk("ct_wrap_gnt1", 64'(rdy_o), 64'h2);
    tick();
    chk_word("ct_wrap_w1", 1, 2, 1'b1, 1'b1, 0);
    drop(1);
    tick();
    chk_idle("ct_done");

    // Backpressure toggling during a 4-word packet on input 1
    put(1, 0, 1'b1, 1'b0, 0);
    tick();
    chk("bp_gnt", 64'(rdy_o), 64'h2);
    tick();
    chk_word("bp_w0", 1, 0, 1'b1, 1'b0, 0);
    put(1, 1, 1'b0, 1'b0, 0); rdy_i = 1'b0;
    #1 chk("bp_stall0", 64'(rdy_o), 64'h0);
    tick();
    chk_word("bp_hold0", 1, 0, 1'b1, 1'b0, 0);
    rdy_i = 1'b1;
    #1 chk("bp_go0", 64'(rdy_o), 64'h2);
    tick();
    chk_word("bp_w1", 1, 1, 1'b0, 1'b0, 0);
    put(1, 2, 1'b0, 1'b0, 0); rdy_i = 1'b0;
    #1 chk("bp_stall1", 64'(rdy_o), 64'h0);
    tick();
    chk_word("bp_hold1", 1, 1, 1'b0, 1'b0, 0);
    rdy_i = 1'b1;
    tick();
    chk_word("bp_w2", 1, 2, 1'b0, 1'b0, 0);
    put(1, 3, 1'b0, 1'b1, 5); rdy_i = 1'b0;
    #1 chk("bp_stall2", 64'(rdy_o), 64'h0);
    tick();
    chk_word("bp_hold2", 1, 2, 1'b0, 1'b0, 0);
    rdy_i = 1'b1;
    tick();
    chk_word("bp_w3", 1, 3, 1'b0, 1'b1, 5);
    drop(1);
    tick();
    chk_idle("bp_done");

    // One-word packets alternate between inputs 1 and 2
    srst = 1'b1; tick(); srst = 1'b0; tick();
    put(1, 4, 1'b1, 1'b1, 0); put(2, 4, 1'b1, 1'b1, 0);
    tick();
    chk("ow_gnt1a", 64'(rdy_o), 64'h2);
    tick();
    chk_word("ow_a", 1, 4, 1'b1, 1'b1, 0);
    put(1, 5, 1'b1, 1'b1, 0);
    tick();
    chk_idle("ow_gap_a");
    chk("ow_gnt2a", 64'(rdy_o), 64'h4);
    tick();
    chk_word("ow_b", 2, 4, 1'b1, 1'b1, 0);
    put(2, 5, 1'b1, 1'b1, 0);
    tick();
    chk("ow_gnt1b", 64'(rdy_o), 64'h2);
    tick();
    chk_word("ow_c", 1, 5, 1'b1, 1'b1, 0);
    drop(1);
    tick();
    chk("ow_gnt2b", 64'(rdy_o), 64'h4);
    tick();
    chk_word("ow_d", 2, 5, 1'b1, 1'b1, 0);
    drop(2);
    tick();
    chk_idle("ow_done");

    // Reset after word 2 of a 5-word packet on input 3
    put(3, 0, 1'b1, 1'b0, 0);
    tick();
    chk("mr_gnt3", 64'(rdy_o), 64'h8);
    tick();
    chk_word("mr_w0", 3, 0, 1'b1, 1'b0, 0);
    put(3, 1, 1'b0, 1'b0, 0);
    tick();
    chk_word("mr_w1", 3, 1, 1'b0, 1'b0, 0);
    put(3, 2, 1'b0, 1'b0, 0); srst = 1'b1;
    #1 chk("mr_rdy_in_rst", 64'(rdy_o), 64'h0);
    tick();
    chk_idle("mr_flush");
    chk("mr_flush_data", 64'(d_o), 64'h0);
    chk("mr_flush_dir", 64'(dir_o), 64'h0);
    drop(3); srst = 1'b0;
    put(0, 0, 1'b1, 1'b0, 0);
    #1 chk("mr_rdy_post", 64'(rdy_o), 64'h0);
    tick();
    chk("mr_gnt0", 64'(rdy_o), 64'h1);
    tick();
    chk_word("mr_n0", 0, 0, 1'b1, 1'b0, 0);
    put(0, 1, 1'b0, 1'b1, 2);
    tick();
    chk_word("mr_n1", 0, 1, 1'b0, 1'b1, 2);
    drop(0);
    tick();
    chk_idle("mr_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ast_mux.md
Name: ast_mux

Overview:
- Packet-aware N:1 Avalon-ST multiplexer; the converse of the stream demux.
- Merges RX_DIR independent input streams into one output stream.
- Arbitrates round-robin on packet boundaries, so packets are never interleaved.
- Reports which input each output word came from on dir_o; sits at the collecting end of the demux datapath in the test fabric.

Parameters:
- DATA_WIDTH, 64, data bus width in bits (multiple of 8).
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8), width of the empty field.
- CHANNEL_WIDTH, 10, width of the channel field.
- RX_DIR, 4, number of input streams (>= 2).
- DIR_SEL_WIDTH, $clog2(RX_DIR), width of the source index.

Ports:
- clk  input  1  clock.
- srst  input  1  synchronous active-high reset.
- ast_data_i  input  RX_DIR*DATA_WIDTH  input data, slice k = input k.
- ast_startofpacket_i  input  RX_DIR  per-input SOP.
- ast_endofpacket_i  input  RX_DIR  per-input EOP.
- ast_valid_i  input  RX_DIR  per-input valid.
- ast_empty_i  input  RX_DIR*EMPTY_WIDTH  per-input empty.
- ast_channel_i  input  RX_DIR*CHANNEL_WIDTH  per-input channel.
- ast_ready_o  output  RX_DIR  per-input ready.
- ast_data_o  output  DATA_WIDTH  output data.
- ast_startofpacket_o  output  1  output SOP.
- ast_endofpacket_o  output  1  output EOP.
- ast_valid_o  output  1  output valid.
- ast_empty_o  output  EMPTY_WIDTH  output empty.
- ast_channel_o  output  CHANNEL_WIDTH  output channel.
- dir_o  output  DIR_SEL_WIDTH  source input index of the current output word.
- ast_ready_i  input  1  downstream ready.

Behaviour:
- Interface timing: one clock (clk); reset srst is synchronous and active-high.
- Handshake: Avalon-ST, ready latency 0.
  - A transfer occurs on any edge where valid=1 and ready=1.
  - Inputs must hold their values while valid=1 and ready=0.
- Reset: while srst=1, and on the cycle after it deasserts:
  - all ast_*_o outputs, ast_ready_o and dir_o are 0;
  - FSM is in IDLE; round-robin pointer rr_ptr = RX_DIR-1, so input 0 has first priority.
- FSM has two states, IDLE and BUSY; grant register gnt has width DIR_SEL_WIDTH.
- IDLE:
  - ast_ready_o = 0.
  - Pick the first k with ast_valid_i[k]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo RX_DIR.
  - If one is found: gnt <= k and go to BUSY on the next edge. This costs one arbitration bubble cycle.
  - If none is found: stay in IDLE.
- BUSY:
  - ast_ready_o[gnt] = ast_ready_i | ~ast_valid_o; all other ready bits are 0.
  - On each input transfer, the output register loads data/sop/eop/empty/channel from slice gnt, sets ast_valid_o=1 and dir_o=gnt.
  - Input transfer with eop=1: go to IDLE and set rr_ptr <= gnt.
- Output register (single stage, latency 1 cycle from input transfer to ast_valid_o):
  - Clears ast_valid_o when an output transfer occurs and no new input transfer happens on the same edge.
  - Simultaneous output and input transfer: new word is loaded and valid stays 1, giving full throughput.
  - ast_ready_i is combinationally forwarded to the granted input only.
- Backpressure:
  - ast_ready_i=0 with ast_valid_o=1 holds all outputs stable.
  - ast_ready_o[gnt] drops in the same cycle.
- SOP/EOP rules:
  - A word with both sop=1 and eop=1 (one-word packet) returns to IDLE after one transfer.
  - A word without sop arriving as the first word of a grant is forwarded unchanged; no checking.
- ast_empty_o is meaningful only when ast_endofpacket_o=1; it is forwarded verbatim.
- Inputs that deassert valid mid-packet keep the grant; the mux waits in BUSY indefinitely.
- srst mid-packet:
  - Immediate return to the reset state; the in-flight output word is discarded.
  - Inputs must restart at a packet boundary.

Optional Feature:
- Macro: AST_MUX_CHANNEL_FROM_DIR_EN.
- Defined: ast_channel_o = gnt zero-extended to CHANNEL_WIDTH, and ast_channel_i is ignored. Requires CHANNEL_WIDTH >= DIR_SEL_WIDTH, enforced by an elaboration-time check.
- Not defined: ast_channel_o carries ast_channel_i of the granted input verbatim.

Test Plan:
- Reset: hold srst=1 for 2 cycles with all inputs valid -> all outputs 0 and ast_ready_o=4'b0000 throughout; first grant afterwards goes to input 0.
- Single packet on input 2: 3 words D0..D2, sop on D0, eop on D2 with empty=3, ast_ready_i=1 -> output D0..D2 on consecutive cycles starting 2 cycles after valid, dir_o=2, last word empty_o=3.
- Contention: inputs 0, 1 and 3 each present a 2-word packet simultaneously -> output order is input 0, 1, 3, with no interleaving and one idle cycle between packets; next round restarts after 3, at input 0.
- Backpressure: ast_ready_i toggles 1,0,1,0 during a 4-word packet -> no word lost or duplicated, outputs stable while ready=0, ast_ready_o[gnt] mirrors the stall.
- One-word packets: input 1 sends sop=eop=1 packets back-to-back with input 2 also requesting -> grants alternate 1,2,1,2.
- Reset mid-packet: assert srst after word 2 of a 5-word packet on input 3 -> ast_valid_o=0 on the next cycle; a new packet from input 0 is then forwarded intact. With AST_MUX_CHANNEL_FROM_DIR_EN defined, ast_channel_o=0 for that packet.
